// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a requested amount of change from five coin tubes. The coin is
// chosen greedily: the highest-value coin that still fits and whose tube is
// both present and not yet found jammed in this transaction.
// A tube that never acknowledges within TIMEOUT cycles is masked off for the
// rest of the transaction and selection is retried with the other tubes.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle pay request, honoured in IDLE only
//   amount      cents to pay (0..125), sampled with start
//   coin_avail  tube-not-empty flags {100c, 50c, 25c, 10c, 5c}
//   eject_ack   coin mechanism acknowledge
//   eject       one-hot eject request, same bit order as coin_avail
//   busy        transaction in progress
//   done        one-cycle pulse, full amount paid
//   error       one-cycle pulse, amount cannot be paid
//   remaining   cents still owed
//   coins_out   coins released this transaction, saturating at 15
//   fsm_state   current FSM state, for debug and checkers
//
// eject/eject_ack handshake: eject holds a one-hot request until eject_ack is
// sampled high (the coin is released) or TIMEOUT cycles pass without it.
// After a released coin the FSM waits in RELEASE for eject_ack to drop, so a
// single long acknowledge can never count as two coins.
module change_dispenser #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] amount,
   input  logic [4:0] coin_avail,
   input  logic       eject_ack,
   output logic [4:0] eject,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [6:0] remaining,
   output logic [3:0] coins_out,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      EJECT   = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4,
      ERROR   = 3'd5
   } state_t;

   // The counter only has to reach TIMEOUT-1: it is cleared on entry to EJECT,
   // so the request is visible for exactly TIMEOUT cycles.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state, state_n;
   logic [4:0]    eject_n;
   logic          busy_n, done_n, error_n;
   logic [6:0]    remaining_n;
   logic [3:0]    coins_n;
   logic [4:0]    mask, mask_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [4:0]    avail;
   logic [4:0]    pick;
   logic          pick_found;

   function automatic logic [6:0] value_at(input int idx);
      case (idx)
         0:       value_at = 7'd5;
         1:       value_at = 7'd10;
         2:       value_at = 7'd25;
         3:       value_at = 7'd50;
         4:       value_at = 7'd100;
         default: value_at = 7'd0;
      endcase
   endfunction

   function automatic logic [6:0] value_of(input logic [4:0] onehot);
      case (onehot)
         5'b00001: value_of = 7'd5;
         5'b00010: value_of = 7'd10;
         5'b00100: value_of = 7'd25;
         5'b01000: value_of = 7'd50;
         5'b10000: value_of = 7'd100;
         default:  value_of = 7'd0;
      endcase
   endfunction

   assign avail     = coin_avail & mask;
   assign fsm_state = state;

   // Greedy pick: scan from the dollar tube down, first fit wins.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         if (!pick_found && avail[i] && (value_at(i) <= remaining)) begin
            pick_found = 1'b1;
            pick[i]    = 1'b1;
         end
      end
   end

   always_comb begin
      state_n     = state;
      eject_n     = eject;
      busy_n      = busy;
      done_n      = 1'b0;
      error_n     = 1'b0;
      remaining_n = remaining;
      coins_n     = coins_out;
      mask_n      = mask;
      cnt_n       = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               remaining_n = amount;
               coins_n     = '0;
               mask_n      = '1;
               busy_n      = 1'b1;
               state_n     = SELECT;
            end
         end
         SELECT: begin
            if ((remaining % 7'd5) != 7'd0) begin
               error_n = 1'b1;
               busy_n  = 1'b0;
               state_n = ERROR;
            end else if (remaining == 7'd0) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = DONE;
            end else if (pick_found) begin
               eject_n = pick;
               cnt_n   = '0;
               state_n = EJECT;
            end else begin
               error_n = 1'b1;
               busy_n  = 1'b0;
               state_n = ERROR;
            end
         end
         EJECT: begin
            if (eject_ack) begin
               // The selected coin never exceeds remaining, so no underflow.
               remaining_n = remaining - value_of(eject);
               coins_n     = (coins_out == 4'hF) ? coins_out : coins_out + 4'd1;
               eject_n     = '0;
               state_n     = RELEASE;
            end else if (cnt == CNT_LAST) begin
               mask_n  = mask & ~eject;
               eject_n = '0;
               state_n = SELECT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RELEASE: begin
            eject_n = '0;
            if (!eject_ack) state_n = SELECT;
         end
         DONE:    state_n = IDLE;
         ERROR:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         eject     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         remaining <= '0;
         coins_out <= '0;
         mask      <= '1;
         cnt       <= '0;
      end else begin
         state     <= state_n;
         eject     <= eject_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= error_n;
         remaining <= remaining_n;
         coins_out <= coins_n;
         mask      <= mask_n;
         cnt       <= cnt_n;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Self-checking bench for change_dispenser. A behavioural model computes the
// coin sequence, final balance, coin count and completion cycle of each
// transaction from the payout rules; a coin-mechanism responder acknowledges
// ejects with a configurable delay and hold, and can leave chosen tubes jammed.
module tb_change_dispenser;

   localparam int TO     = 15;
   localparam int N_RAND = 40;

   logic       clk;
   logic       reset;
   logic       start;
   logic [6:0] amount;
   logic [4:0] coin_avail;
   logic       eject_ack;
   logic [4:0] eject;
   logic       busy;
   logic       done;
   logic       error;
   logic [6:0] remaining;
   logic [3:0] coins_out;
   logic [2:0] fsm_state;

   change_dispenser #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .amount     (amount),
      .coin_avail (coin_avail),
      .eject_ack  (eject_ack),
      .eject      (eject),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .remaining  (remaining),
      .coins_out  (coins_out),
      .fsm_state  (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model results
   logic [4:0] exp_q[$];
   int         exp_len_q[$];
   bit         exp_ok;
   int         exp_rem, exp_coins, exp_end;

   // observed results
   logic [4:0] obs_q[$];
   int         obs_len[$];
   int         n_done, n_err, end_cyc, busy_cyc, multi_hot, hold_viol, hold_drift;
   logic [6:0] fin_rem;
   logic [3:0] fin_coins;
   logic       busy_at_end;

   // Cycle numbering: start is driven at cycle 0; cycle n is the n-th falling
   // edge after that. exp_end is the cycle at which done/error is visible.
   function automatic void model(input int amt, input logic [4:0] av, input logic [4:0] jam,
                                 input int dly, input int hold);
      int vals[5] = '{5, 10, 25, 50, 100};
      int rem, k;
      logic [4:0] m;
      rem = amt; m = 5'b11111;
      exp_q.delete(); exp_len_q.delete();
      exp_coins = 0; exp_end = 1; exp_ok = 1'b0;
      for (int g = 0; g < 64; g++) begin
         if (rem % 5 != 0) break;
         if (rem == 0) begin exp_ok = 1'b1; break; end
         k = -1;
         for (int j = 4; j >= 0; j--)
            if (k < 0 && av[j] && m[j] && vals[j] <= rem) k = j;
         if (k < 0) break;
         exp_q.push_back(5'(1 << k));
         if (jam[k]) begin
            exp_len_q.push_back(TO);
            m[k] = 1'b0;
            exp_end += TO + 1;
         end else begin
            exp_len_q.push_back(dly);
            rem -= vals[k];
            if (exp_coins < 15) exp_coins++;
            exp_end += dly + hold + 2;
         end
      end
      exp_rem = rem;
      exp_end += 1;
   endfunction

   // Driver + coin-mechanism responder; records what the DUT did.
   task automatic run_txn(input logic [6:0] amt, input logic [4:0] av, input logic [4:0] jam,
                          input int dly, input int hold, input int restart_at, input int budget);
      int cyc, waitc, hcnt, post;
      bit hold_ph;
      logic [4:0] prev;
      obs_q.delete(); obs_len.delete();
      n_done = 0; n_err = 0; end_cyc = -1; busy_cyc = 0; multi_hot = 0;
      hold_viol = 0; hold_drift = 0; fin_rem = '0; fin_coins = '0; busy_at_end = 1'b0;
      @(negedge clk);
      start = 1'b1; amount = amt; coin_avail = av; eject_ack = 1'b0;
      cyc = 0; waitc = 0; hcnt = 0; post = 0; hold_ph = 1'b0; prev = '0;
      while (cyc < budget && post < 3) begin
         @(negedge clk);
         cyc++;
         start  = (cyc == restart_at);
         amount = 7'($urandom_range(0, 127));
         if (busy) busy_cyc++;
         if (done) n_done++;
         if (error) n_err++;
         if ((done || error) && end_cyc < 0) begin
            end_cyc = cyc; fin_rem = remaining; fin_coins = coins_out; busy_at_end = busy;
         end
         if (end_cyc >= 0) begin
            post++;
            if (remaining !== fin_rem || coins_out !== fin_coins) hold_drift++;
         end
         if ($countones(eject) > 1) multi_hot++;
         if (eject != 5'b0) begin
            if (hold_ph) hold_viol++;
            if (prev == 5'b0) begin
               obs_q.push_back(eject); obs_len.push_back(0); waitc = 0;
            end
            obs_len[obs_len.size()-1] += 1;
            waitc++;
            if ((eject & jam) == 5'b0 && waitc >= dly) begin eject_ack = 1'b1; hcnt = 0; end
         end else if (eject_ack) begin
            hold_ph = 1'b1;
            if (hcnt >= hold) begin eject_ack = 1'b0; hold_ph = 1'b0; end
            else hcnt++;
         end
         prev = eject;
      end
      start = 1'b0; eject_ack = 1'b0;
   endtask

   task automatic test_reset();
      start = 1'b0; amount = '0; coin_avail = '1; eject_ack = 1'b0;
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (eject !== 5'b0) begin bad++; $display("FAIL reset_eject: got %b want 00000", eject); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL reset_pulses: got done=%b error=%b want 0 0", done, error); end
      total++; if (remaining !== 7'd0) begin bad++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
      total++; if (coins_out !== 4'd0) begin bad++; $display("FAIL reset_coins: got %0d want 0", coins_out); end
      total++; if (fsm_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
      // first edge with reset high accepts start
      @(negedge clk);
      reset = 1'b1; start = 1'b1; amount = 7'd0;
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start_busy: got %b want 1", busy); end
      @(negedge clk);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL first_start_done: got done=%b busy=%b want 1 0", done, busy); end
      @(negedge clk);
   endtask

   task automatic test_payout();
      logic [6:0] d_amt [7] = '{7'd40, 7'd0, 7'd33, 7'd30, 7'd15, 7'd25, 7'd125};
      logic [4:0] d_av  [7] = '{5'b11111, 5'b11111, 5'b11111, 5'b10011, 5'b00010, 5'b11111, 5'b00001};
      logic [4:0] d_jam [7] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b0};
      int d_dly  [7] = '{2, 2, 1, 1, 2, 1, 1};
      int d_rem  [7] = '{0, 0, 33, 0, 5, 0, 0};
      int d_coin [7] = '{3, 0, 0, 3, 1, 3, 15};
      for (int i = 0; i < 7 + N_RAND; i++) begin
         logic [6:0] amt;
         logic [4:0] av, jam;
         int dly, hold, rs;
         bit seq_bad;
         if (i < 7) begin
            amt = d_amt[i]; av = d_av[i]; jam = d_jam[i]; dly = d_dly[i]; hold = 0;
         end else begin
            amt  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'(5 * $urandom_range(0, 25));
            av   = 5'($urandom_range(0, 31));
            jam  = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
            dly  = $urandom_range(1, 3);
            hold = $urandom_range(0, 2);
         end
         model(int'(amt), av, jam, dly, hold);
         rs = (i < 7) ? 0 : $urandom_range(2, exp_end);
         run_txn(amt, av, jam, dly, hold, rs, exp_end + 20);
         total++; if (end_cyc < 0) begin bad++; $display("FAIL payout[%0d] finish: got no done/error want cycle %0d", i, exp_end); end
         total++; if (end_cyc !== exp_end) begin bad++; $display("FAIL payout[%0d] end_cycle: got %0d want %0d", i, end_cyc, exp_end); end
         total++; if (n_done !== (exp_ok ? 1 : 0)) begin bad++; $display("FAIL payout[%0d] done_pulses: got %0d want %0d", i, n_done, exp_ok ? 1 : 0); end
         total++; if (n_err !== (exp_ok ? 0 : 1)) begin bad++; $display("FAIL payout[%0d] error_pulses: got %0d want %0d", i, n_err, exp_ok ? 0 : 1); end
         total++; if (fin_rem !== 7'(exp_rem)) begin bad++; $display("FAIL payout[%0d] remaining: got %0d want %0d", i, fin_rem, exp_rem); end
         total++; if (fin_coins !== 4'(exp_coins)) begin bad++; $display("FAIL payout[%0d] coins_out: got %0d want %0d", i, fin_coins, exp_coins); end
         seq_bad = (obs_q.size() != exp_q.size());
         if (!seq_bad)
            for (int j = 0; j < exp_q.size(); j++)
               if (obs_q[j] !== exp_q[j] || obs_len[j] != exp_len_q[j]) seq_bad = 1'b1;
         total++; if (seq_bad) begin bad++; $display("FAIL payout[%0d] eject_seq: got %0d ejects want %0d (amount %0d avail %b jam %b)", i, obs_q.size(), exp_q.size(), amt, av, jam); end
         total++; if (busy_cyc !== exp_end - 1) begin bad++; $display("FAIL payout[%0d] busy_cycles: got %0d want %0d", i, busy_cyc, exp_end - 1); end
         total++; if (busy_at_end !== 1'b0) begin bad++; $display("FAIL payout[%0d] busy_at_end: got %b want 0", i, busy_at_end); end
         total++; if (multi_hot !== 0 || hold_drift !== 0 || hold_viol !== 0) begin bad++; $display("FAIL payout[%0d] protocol: got multi_hot=%0d drift=%0d hold_viol=%0d want 0 0 0", i, multi_hot, hold_drift, hold_viol); end
         if (i < 7) begin
            total++; if (fin_rem !== 7'(d_rem[i])) begin bad++; $display("FAIL payout[%0d] table_remaining: got %0d want %0d", i, fin_rem, d_rem[i]); end
            total++; if (fin_coins !== 4'(d_coin[i])) begin bad++; $display("FAIL payout[%0d] table_coins: got %0d want %0d", i, fin_coins, d_coin[i]); end
         end
      end
   endtask

   task automatic test_ack_idle();
      eject_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (eject !== 5'b0 || busy !== 1'b0 || remaining !== 7'(exp_rem) || coins_out !== 4'(exp_coins)) begin
            bad++;
            $display("FAIL ack_idle[%0d]: got eject=%b busy=%b rem=%0d coins=%0d want 00000 0 %0d %0d",
                     i, eject, busy, remaining, coins_out, exp_rem, exp_coins);
         end
      end
      eject_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_busy_restart();
      model(40, 5'b11111, 5'b0, 2, 5);
      run_txn(7'd40, 5'b11111, 5'b0, 2, 5, 5, exp_end + 20);
      total++; if (end_cyc !== exp_end) begin bad++; $display("FAIL restart end_cycle: got %0d want %0d", end_cyc, exp_end); end
      total++; if (hold_viol !== 0) begin bad++; $display("FAIL restart eject_during_ack: got %0d want 0", hold_viol); end
      total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL restart eject_count: got %0d want 3", obs_q.size()); end
      total++; if (n_done !== 1 || fin_rem !== 7'd0 || fin_coins !== 4'd3) begin bad++; $display("FAIL restart result: got done=%0d rem=%0d coins=%0d want 1 0 3", n_done, fin_rem, fin_coins); end
   endtask

   task automatic test_reset_mid_eject();
      logic [4:0] seen;
      @(negedge clk);
      start = 1'b1; amount = 7'd100; coin_avail = 5'b11111; eject_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      seen = '0;
      for (int i = 0; i < 8 && seen == 5'b0; i++) begin
         @(negedge clk);
         seen = eject;
      end
      total++; if (seen !== 5'b10000) begin bad++; $display("FAIL mid_reset pre_eject: got %b want 10000", seen); end
      #2 reset = 1'b0;
      #1;
      total++; if (eject !== 5'b0) begin bad++; $display("FAIL mid_reset eject: got %b want 00000", eject); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset busy: got %b want 0", busy); end
      total++; if (remaining !== 7'd0 || coins_out !== 4'd0) begin bad++; $display("FAIL mid_reset counters: got rem=%0d coins=%0d want 0 0", remaining, coins_out); end
      @(negedge clk);
      reset = 1'b1;
      model(5, 5'b11111, 5'b0, 1, 0);
      run_txn(7'd5, 5'b11111, 5'b0, 1, 0, 0, exp_end + 20);
      total++; if (obs_q.size() !== 1 || (obs_q.size() == 1 && obs_q[0] !== 5'b00001)) begin bad++; $display("FAIL mid_reset nickel: got %0d ejects want 1 nickel", obs_q.size()); end
      total++; if (n_done !== 1 || end_cyc !== exp_end) begin bad++; $display("FAIL mid_reset done: got done=%0d at %0d want 1 at %0d", n_done, end_cyc, exp_end); end
      total++; if (fin_rem !== 7'd0 || fin_coins !== 4'd1) begin bad++; $display("FAIL mid_reset result: got rem=%0d coins=%0d want 0 1", fin_rem, fin_coins); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time %0t want bench finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_payout();
      test_ack_idle();
      test_busy_restart();
      test_reset_mid_eject();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles eject waits for eject_ack before that tube is declared jammed/empty.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 start  input  1  one-cycle request to pay out amount; sampled in IDLE only.
REQ-005 amount  input  7  change to pay, cents, 0..125; sampled with start.
REQ-006 coin_avail  input  5  tube-not-empty flags: [0] nickel 5c, [1] dime 10c, [2] quarter 25c, [3] half 50c, [4] dollar 100c.
REQ-007 eject_ack  input  1  coin mechanism acknowledge; high = current coin released.
REQ-008 eject  output  5  one-hot eject request, same bit order as coin_avail; held until ack or timeout.
REQ-009 busy  output  1  high from cycle after accepted start until return to IDLE.
REQ-010 done  output  1  one-cycle pulse: remaining reached 0.
REQ-011 error  output  1  one-cycle pulse: change cannot be completed.
REQ-012 remaining  output  7  cents still owed.
REQ-013 coins_out  output  4  coins ejected in current transaction, saturating at 15.

Function
REQ-014 States: IDLE, SELECT, EJECT, RELEASE, DONE, ERROR; all outputs registered.
REQ-015 IDLE + start: latch remaining=amount, coins_out=0, internal mask=5'b11111, busy=1; next SELECT. start in any other state ignored.
REQ-016 SELECT (one cycle): avail = coin_avail & mask; amount%5!=0 -> ERROR; remaining==0 -> DONE; else pick highest-value coin with avail bit set and value <= remaining -> EJECT with that eject bit; none -> ERROR.
REQ-017 EJECT: eject one-hot held; timeout counter increments each cycle, cleared on entry.
REQ-018 EJECT + eject_ack: remaining -= coin value, coins_out += 1 (saturate), eject=0; next RELEASE.
REQ-019 EJECT, counter reaches TIMEOUT without ack: clear that mask bit, eject=0, remaining unchanged; next SELECT.
REQ-020 RELEASE: eject=0; wait eject_ack low, then SELECT; ack stuck high holds RELEASE indefinitely.
REQ-021 DONE: done=1 one cycle, busy=0 same cycle as return to IDLE; remaining/coins_out hold final values until next start.
REQ-022 ERROR: error=1 one cycle; remaining holds unpaid balance; back to IDLE.
REQ-023 Latency: start at edge N -> SELECT at N+1 -> eject visible after edge N+2; amount 0 -> done high after edge N+2.
REQ-024 remaining never underflows; subtraction only when value <= remaining (guaranteed by REQ-016).
REQ-025 coin_avail changes during EJECT do not cancel current eject; re-evaluated in next SELECT.
REQ-026 eject_ack in IDLE, SELECT, DONE, ERROR ignored.
REQ-027 At most one eject bit high in any cycle.

Reset
REQ-028 reset low: state=IDLE, eject=0, busy=0, done=0, error=0, remaining=0, coins_out=0, mask=5'b11111, timeout counter=0, immediately, including mid-EJECT.
REQ-029 After reset release, first start accepted on first rising edge with reset high.

Verification
REQ-030 amount=40, coin_avail=5'b11111, ack 2 cycles after each eject -> eject 00100, 00010, 00001; done pulse; remaining=0; coins_out=3.
REQ-031 amount=0 -> no eject, done exactly 2 cycles after start, busy high 1 cycle; amount=33 -> error pulse, remaining=33, no eject.
REQ-032 amount=30, coin_avail=5'b10011 -> three dimes, done, coins_out=3; amount=15, coin_avail=5'b00010 -> one dime then error, remaining=5.
REQ-033 amount=25, quarter never acked, others ack -> quarter eject for TIMEOUT cycles dropped, then dime, dime, nickel; done; coins_out=3.
REQ-034 reset low during EJECT of amount=100 -> eject=0, busy=0, remaining=0 same cycle; later start amount=5 -> single nickel, done.
REQ-035 start pulsed while busy, and ack held high in RELEASE 5 cycles -> second start ignored, next eject only after ack falls.
